mtm_alu_deserializer: RTL and testbench

Receive-side stage of mtm_Alu, directly upstream of the ALU core; the mirror of the output serializer. Samples the 1-bit-per-clock serial input line and assembles 8 data frames into operands B and A. It then consumes one control frame carrying OP and a CRC4. It checks frame count and CRC, then presents A/B/OP with a one-cycle valid pulse or an error pulse to the core.

---
 rtl/mtm_alu_pkg.sv | 43 ++++
 rtl/mtm_alu_deserializer_if.sv | 30 +++
 rtl/mtm_alu_crc4_step.sv | 16 +
 rtl/mtm_alu_deserializer.sv | 156 +++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg
// Shared definitions for the mtm_Alu receive path and core:
//   - frame type constants (data / control)
//   - number of data frames per packet
//   - CRC4 polynomial (x^4 + x + 1) and a single-bit CRC4 update helper
//   - OP encodings shared with the ALU core
//   - deserializer FSM state encoding
package mtm_alu_pkg;

  // Frame type bit, second bit of every frame
  localparam logic FT_DATA = 1'b0;
  localparam logic FT_CTL  = 1'b1;

  // Data frames per packet: B[31:24] .. B[7:0], A[31:24] .. A[7:0]
  localparam logic [3:0] N_DATA_FRAMES = 4'd8;

  // x^4 + x + 1 with the implicit x^4 term dropped
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  // Operation codes shared with the ALU core
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  // Deserializer FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_STOP    = 2'd3
  } des_state_e;

  // One serial MSB-first CRC4 step: fb = crc[3]^bit, shift left, xor poly on fb
  function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic din);
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// mtm_alu_deserializer_if
// Bus between the serial line / ALU core side and the deserializer.
//   sin      : serial input, one bit per clock, idles high
//   A, B     : assembled operands, held until the next good packet
//   op       : operation code from the control frame
//   d_valid  : one-cycle pulse, A/B/op updated with a good packet
//   err_data : one-cycle pulse, bad frame count or framing error
//   err_crc  : one-cycle pulse, CRC4 mismatch
// Modports: master drives sin and observes results; slave is the deserializer.
interface mtm_alu_deserializer_if;

  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        d_valid;
  logic        err_data;
  logic        err_crc;

  modport master (
    output sin,
    input  A, B, op, d_valid, err_data, err_crc
  );

  modport slave (
    input  sin,
    output A, B, op, d_valid, err_data, err_crc
  );

endinterface

// File: rtl/mtm_alu_crc4_step.sv
// mtm_alu_crc4_step
// Combinational single-bit CRC4 update (polynomial x^4 + x + 1, MSB first).
//   i_crc : current CRC value
//   i_bit : next message bit
//   o_crc : CRC after folding in i_bit
module mtm_alu_crc4_step
  import mtm_alu_pkg::*;
(
  input  logic [3:0] i_crc,
  input  logic       i_bit,
  output logic [3:0] o_crc
);

  assign o_crc = crc4_next(i_crc, i_bit);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer
// Receive stage of mtm_Alu. Samples the serial line one bit per clock,
// assembles 8 data frames into {B, A}, then evaluates a control frame
// carrying OP and CRC4 and reports exactly one of d_valid / err_data /
// err_crc per packet, one cycle after the control stop bit.
// Ports:
//   clk : system clock, one serial bit per rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of mtm_alu_deserializer_if (sin in; A, B, op and
//         status pulses out, all registered)
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  mtm_alu_deserializer_if.slave bus
);

  des_state_e  r_state;
  logic [2:0]  r_bit_cnt;
  logic        r_type;
  logic [7:0]  r_byte;
  logic [63:0] r_shift;
  logic [3:0]  r_count;
  logic        r_overrun;
  logic [3:0]  r_crc;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_d_valid;
  logic        r_err_data;
  logic        r_err_crc;

  logic [3:0]  w_crc_serial;
  logic [2:0]  w_ctl_op;
  logic [3:0]  w_ctl_crc;
  logic [3:0]  w_crc_t1;
  logic [3:0]  w_crc_t2;
  logic [3:0]  w_crc_t3;
  logic [3:0]  w_crc_t4;
  logic        w_count_ok;
  logic        w_crc_ok;

  // Control byte layout: {1'b0, OP[2:0], CRC[3:0]}
  assign w_ctl_op  = r_byte[6:4];
  assign w_ctl_crc = r_byte[3:0];

  // Serial path: data payload bits folded in as they arrive
  mtm_alu_crc4_step u_crc_serial (
    .i_crc (r_crc),
    .i_bit (bus.sin),
    .o_crc (w_crc_serial)
  );

  // Tail {1'b1, OP} folded in combinationally when the ctl frame is evaluated
  mtm_alu_crc4_step u_crc_tail0 (.i_crc(r_crc),    .i_bit(1'b1),        .o_crc(w_crc_t1));
  mtm_alu_crc4_step u_crc_tail1 (.i_crc(w_crc_t1), .i_bit(w_ctl_op[2]), .o_crc(w_crc_t2));
  mtm_alu_crc4_step u_crc_tail2 (.i_crc(w_crc_t2), .i_bit(w_ctl_op[1]), .o_crc(w_crc_t3));
  mtm_alu_crc4_step u_crc_tail3 (.i_crc(w_crc_t3), .i_bit(w_ctl_op[0]), .o_crc(w_crc_t4));

  assign w_count_ok = (r_count == N_DATA_FRAMES) && !r_overrun;
  assign w_crc_ok   = (w_crc_t4 == w_ctl_crc);

  // Frame FSM, packet accounting and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_type     <= FT_DATA;
      r_byte     <= 8'h00;
      r_shift    <= 64'h0;
      r_count    <= 4'd0;
      r_overrun  <= 1'b0;
      r_crc      <= 4'h0;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_op       <= 3'd0;
      r_d_valid  <= 1'b0;
      r_err_data <= 1'b0;
      r_err_crc  <= 1'b0;
    end else begin
      r_d_valid  <= 1'b0;
      r_err_data <= 1'b0;
      r_err_crc  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.sin) begin
            r_state <= ST_TYPE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_TYPE: begin
          r_type    <= bus.sin;
          r_bit_cnt <= 3'd0;
          r_state   <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          r_byte    <= {r_byte[6:0], bus.sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          // Only data payload contributes to the serial CRC; the ctl byte holds the CRC itself
          if (r_type == FT_DATA) begin
            r_crc <= w_crc_serial;
          end
          if (r_bit_cnt == 3'd7) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
          if (!bus.sin) begin
            // Framing error: drop the whole packet
            r_err_data <= 1'b1;
            r_count    <= 4'd0;
            r_overrun  <= 1'b0;
            r_crc      <= 4'h0;
          end else if (r_type == FT_DATA) begin
            if (r_count < N_DATA_FRAMES) begin
              r_shift <= {r_shift[55:0], r_byte};
              r_count <= r_count + 4'd1;
            end else begin
              // Sticky until the ctl frame so extra frames cannot be mistaken for a good packet
              r_overrun <= 1'b1;
            end
          end else begin
            if (!w_count_ok) begin
              r_err_data <= 1'b1;
            end else if (!w_crc_ok) begin
              r_err_crc <= 1'b1;
            end else begin
              r_b       <= r_shift[63:32];
              r_a       <= r_shift[31:0];
              r_op      <= w_ctl_op;
              r_d_valid <= 1'b1;
            end
            r_count   <= 4'd0;
            r_overrun <= 1'b0;
            r_crc     <= 4'h0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.A        = r_a;
  assign bus.B        = r_b;
  assign bus.op       = r_op;
  assign bus.d_valid  = r_d_valid;
  assign bus.err_data = r_err_data;
  assign bus.err_crc  = r_err_crc;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer
// Scoreboard bench: stimulus pushes the expected outcome of each packet
// (kind, cycle, held A/B/op) into a queue; a monitor pops and compares
// whenever the DUT raises a status pulse.
module tb_mtm_alu_deserializer;

  typedef struct {
    logic [2:0]  kind;   // {d_valid, err_data, err_crc}
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_EDATA = 3'b010;
  localparam logic [2:0] K_ECRC  = 3'b001;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   last_stop_cyc;
  exp_t exp_q[$];

  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_op;

  mtm_alu_deserializer_if bus ();

  mtm_alu_deserializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference CRC4: remainder of {B,A,1,OP} * x^4 divided by x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic push_exp(input logic [2:0] kind);
    exp_t e;
    e.kind = kind;
    e.cyc  = last_stop_cyc;
    e.a    = m_a;
    e.b    = m_b;
    e.op   = m_op;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sin = bits[10 - i];
    end
    last_stop_cyc = cyc + 1;
  endtask

  task automatic send_frame(input logic ftype, input logic [7:0] data, input logic stop);
    send_bits({1'b0, ftype, data, stop}, 11);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sin = 1'b1;
    end
  endtask

  // Full packet with ndata data frames; expected outcome follows the packet rules
  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input int ndata, input logic [3:0] crc, input int gap_max);
    logic [63:0] d;
    logic [7:0]  byt;
    d = {b, a};
    for (int i = 0; i < ndata; i++) begin
      byt = (i < 8) ? d[63 - 8*i -: 8] : 8'($urandom);
      send_frame(1'b0, byt, 1'b1);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    if (ndata != 8) begin
      push_exp(K_EDATA);
    end else if (crc != ref_crc(b, a, op)) begin
      push_exp(K_ECRC);
    end else begin
      m_a  = a;
      m_b  = b;
      m_op = op;
      push_exp(K_VALID);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_A"}, 64'(bus.A), 64'h0);
    check({tag, "_B"}, 64'(bus.B), 64'h0);
    check({tag, "_op"}, 64'(bus.op), 64'h0);
    check({tag, "_pulses"}, 64'({bus.d_valid, bus.err_data, bus.err_crc}), 64'h0);
  endtask

  // Monitor: every status pulse must match the next expected outcome
  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.d_valid || bus.err_data || bus.err_crc)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got %b expected none (cyc=%0d)",
                 {bus.d_valid, bus.err_data, bus.err_crc}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 64'({bus.d_valid, bus.err_data, bus.err_crc}), 64'(e.kind));
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("A", 64'(bus.A), 64'(e.a));
        check("B", 64'(bus.B), 64'(e.b));
        check("op", 64'(bus.op), 64'(e.op));
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic [3:0]  rcrc;
    int          mode;
    int          nd;
    int          waited;

    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    m_a   = 32'h0;
    m_b   = 32'h0;
    m_op  = 3'd0;
    last_stop_cyc = 0;
    bus.sin = 1'b1;
    rst = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Zero packet, ctl 0x0B
    send_pkt(32'h0, 32'h0, 3'b000, 8, 4'hB, 0);
    idle(3);

    // Operand order, back-to-back frames
    send_pkt(32'h01020304, 32'hA0B0C0D0, 3'b001, 8,
             ref_crc(32'h01020304, 32'hA0B0C0D0, 3'b001), 0);
    idle(2);

    // Bad CRC: zero packet with ctl 0x0A, held values must survive
    send_pkt(32'h0, 32'h0, 3'b000, 8, 4'hA, 0);
    idle(2);

    // Frame count 7 and 9, then a good zero packet
    send_pkt(32'h0, 32'h0, 3'b000, 7, 4'hB, 0);
    idle(1);
    send_pkt(32'h0, 32'h0, 3'b000, 9, 4'hB, 0);
    send_pkt(32'h0, 32'h0, 3'b000, 8, 4'hB, 0);
    idle(2);

    // Framing error on data frame 3, then ctl alone, then a good packet
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0);
    push_exp(K_EDATA);
    send_frame(1'b1, 8'h0B, 1'b1);
    push_exp(K_EDATA);
    send_pkt(32'hDEADBEEF, 32'h12345678, 3'b101, 8,
             ref_crc(32'hDEADBEEF, 32'h12345678, 3'b101), 1);
    idle(2);

    // Randomized packets with random corruption
    for (int p = 0; p < 24; p++) begin
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      rcrc = ref_crc(rb, ra, rop);
      nd   = 8;
      mode = $urandom_range(0, 5);
      if (mode == 3) rcrc = rcrc ^ 4'($urandom_range(1, 15));
      if (mode == 4) nd = ($urandom_range(0, 1) == 0) ? 7 : 9;
      if (mode == 5) nd = $urandom_range(0, 10);
      send_pkt(rb, ra, rop, nd, rcrc, 2);
      idle($urandom_range(0, 3));
    end

    // Reset mid-frame: 4 data frames, then partial frame 5
    send_pkt(32'hCAFEF00D, 32'h0BADC0DE, 3'b100, 8,
             ref_crc(32'hCAFEF00D, 32'h0BADC0DE, 3'b100), 0);
    idle(2);
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'($urandom), 1'b1);
    send_bits({1'b0, 1'b0, 8'hA5, 1'b1}, 5);
    #1;
    rst = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    m_a  = 32'h0;
    m_b  = 32'h0;
    m_op = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.sin = 1'b1;
    idle(2);
    send_pkt(32'h0, 32'h0, 3'b000, 8, 4'hB, 0);

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    idle(5);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
